// File: rtl/correlator_lock.sv
// Integrate-and-dump correlator with a SEARCH/TRACK lock FSM and code-slip requests.
// Optional `CORRELATOR_BIPOLAR_EN: signed +/-1 accumulation with magnitude output.
module correlator_lock #(
  parameter int INT_LEN    = 1024,
  parameter int ACC_W      = 16,
  parameter int OUT_W      = 8,
  parameter int OUT_SHIFT  = 2,
  parameter int LOCK_HITS  = 3,
  parameter int MISS_LIMIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic             sig,
  input  logic             code,
  input  logic [OUT_W-1:0] trigger,
  output logic [OUT_W-1:0] result,
  output logic             result_valid,
  output logic             match,
  output logic             locked,
  output logic             slip
);

  localparam int CNT_W  = $clog2(INT_LEN);
  localparam int HIT_W  = $clog2(LOCK_HITS + 1);
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);
  localparam int SW     = (ACC_W > OUT_W) ? ACC_W : OUT_W;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(INT_LEN - 1);
  localparam logic [HIT_W-1:0]  HIT_LAST  = HIT_W'(LOCK_HITS - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_LIMIT - 1);
  localparam logic [OUT_W-1:0]  OUT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    TRACK  = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic [HIT_W-1:0]   hit_cnt;
  logic [MISS_W-1:0]  miss_cnt;
  logic               sample_bit;
  logic               take;
  logic               dump;
  logic [ACC_W-1:0]   mag;
  logic [SW-1:0]      shifted;
  logic [OUT_W-1:0]   scaled;
  logic               match_n;
  logic               slip_n;
  logic               lock_reach;
  logic               miss_reach;

  assign sample_bit = ~(sig ^ code);
  // start wins over a coincident dump, so it also gates sample acceptance
  assign take = (state != IDLE) && en && !start;
  assign dump = take && (cnt == CNT_LAST);

`ifdef CORRELATOR_BIPOLAR_EN
  logic signed [ACC_W:0] acc, acc_sum;
  logic        [ACC_W:0] acc_neg;

  always_comb begin
    acc_sum = acc + (sample_bit ? (ACC_W+1)'(1) : '1);
    acc_neg = -acc_sum;
    mag     = acc_sum[ACC_W] ? acc_neg[ACC_W-1:0] : acc_sum[ACC_W-1:0];
  end
`else
  logic [ACC_W-1:0] acc, acc_sum;

  always_comb begin
    acc_sum = acc + ACC_W'(sample_bit);
    mag     = acc_sum;
  end
`endif

  always_comb begin
    shifted = SW'(mag) >> OUT_SHIFT;
    scaled  = (shifted > SW'(OUT_MAX)) ? OUT_MAX : shifted[OUT_W-1:0];
    match_n = (scaled >= trigger);
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // FSM: next state
  always_comb begin
    state_n = state;
    if (start) begin
      state_n = SEARCH;
    end else if (dump) begin
      case (state)
        SEARCH:  if (lock_reach) state_n = TRACK;
        TRACK:   if (miss_reach) state_n = SEARCH;
        default: state_n = state;
      endcase
    end
  end

  // FSM: outputs and dump-time decisions
  always_comb begin
    locked     = (state == TRACK);
    lock_reach = (state == SEARCH) && match_n && (hit_cnt == HIT_LAST);
    miss_reach = (state == TRACK) && !match_n && (miss_cnt == MISS_LAST);
    slip_n     = dump && (((state == SEARCH) && !match_n) || miss_reach);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (start) begin
      acc      <= '0;
      cnt      <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (take) begin
      if (dump) begin
        acc <= '0;
        cnt <= '0;
        if (state == SEARCH) begin
          if (!match_n || lock_reach) hit_cnt <= '0;
          else                        hit_cnt <= hit_cnt + HIT_W'(1);
        end else if (state == TRACK) begin
          if (match_n || miss_reach) miss_cnt <= '0;
          else                       miss_cnt <= miss_cnt + MISS_W'(1);
        end
      end else begin
        acc <= acc_sum;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // result and match hold between dumps; the pulses are live for one cycle only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result       <= '0;
      match        <= 1'b0;
      result_valid <= 1'b0;
      slip         <= 1'b0;
    end else begin
      result_valid <= dump;
      slip         <= slip_n;
      if (dump) begin
        result <= scaled;
        match  <= match_n;
      end
    end
  end

endmodule

// File: tb/tb_correlator_lock.sv
// Directed bench for correlator_lock: expected dump records are queued as each
// window's last sample is driven and checked when result_valid appears.
module tb_correlator_lock;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       start = 1'b0;
  logic       sig = 1'b0;
  logic       code = 1'b0;
  logic [7:0] trigger = 8'd200;
  logic [7:0] result;
  logic       result_valid;
  logic       match;
  logic       locked;
  logic       slip;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] res;
    logic       mt;
    logic       lk;
    logic       sl;
  } exp_t;

  exp_t q[$];

`ifdef CORRELATOR_BIPOLAR_EN
  localparam logic [7:0] HALF_RES = 8'd0;
`else
  localparam logic [7:0] HALF_RES = 8'd128;
`endif

  correlator_lock dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .start        (start),
    .sig          (sig),
    .code         (code),
    .trigger      (trigger),
    .result       (result),
    .result_valid (result_valid),
    .match        (match),
    .locked       (locked),
    .slip         (slip)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  // Called 1 time unit after each rising edge.
  task automatic check_cycle();
    exp_t e;
    if (result_valid) begin
      chk("rv_expected", q.size() > 0, 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("result", result, e.res);
        chk("match", match, e.mt);
        chk("locked", locked, e.lk);
        chk("slip", slip, e.sl);
      end
    end else begin
      chk("slip_without_dump", slip, 0);
    end
  endtask

  task automatic drive(input logic e, input logic s, input logic c, input logic st);
    en    = e;
    sig   = s;
    code  = c;
    start = st;
    @(posedge clk);
    #1;
    check_cycle();
  endtask

  task automatic pulse_start();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    start = 1'b0;
  endtask

  // Samples [0, n_agree) agree, the rest disagree; 'gap' idle cycles precede each sample.
  task automatic run_window(input int n_agree, input int n_dis, input int gap,
                            input logic [7:0] trig, input logic [7:0] exp_res,
                            input logic exp_mt, input logic exp_lk, input logic exp_sl);
    int   n;
    logic s;
    exp_t e;
    trigger = trig;
    n = n_agree + n_dis;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++)
        drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      s = 1'($urandom_range(0, 1));
      if (i == n - 1) begin
        e.res = exp_res;
        e.mt  = exp_mt;
        e.lk  = exp_lk;
        e.sl  = exp_sl;
        q.push_back(e);
      end
      drive(1'b1, s, (i < n_agree) ? s : ~s, 1'b0);
    end
    en = 1'b0;
    chk("rv_arrived", q.size(), 0);
    q.delete();
  endtask

  initial begin
    #1;
    chk("rst_result", result, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_match", match, 0);
    chk("rst_locked", locked, 0);
    chk("rst_slip", slip, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // full agreement, then half agreement
    pulse_start();
    run_window(1024, 0, 0, 8'd200, 8'd255, 1'b1, 1'b0, 1'b0);
    run_window(512, 512, 0, 8'd200, HALF_RES, 1'b0, 1'b0, 1'b1);

    // three hits to lock, window 4 back-to-back
    run_window(1024, 0, 0, 8'd200, 8'd255, 1'b1, 1'b0, 1'b0);
    run_window(1024, 0, 0, 8'd200, 8'd255, 1'b1, 1'b0, 1'b0);
    run_window(1024, 0, 0, 8'd200, 8'd255, 1'b1, 1'b1, 1'b0);
    run_window(1024, 0, 0, 8'd200, 8'd255, 1'b1, 1'b1, 1'b0);

    // miss, hit keeps lock; two misses drop it with a slip
    run_window(512, 512, 0, 8'd200, HALF_RES, 1'b0, 1'b1, 1'b0);
    run_window(1024, 0, 0, 8'd200, 8'd255, 1'b1, 1'b1, 1'b0);
    run_window(512, 512, 0, 8'd200, HALF_RES, 1'b0, 1'b1, 1'b0);
    run_window(512, 512, 0, 8'd200, HALF_RES, 1'b0, 1'b0, 1'b1);

    // en every third cycle
    pulse_start();
    run_window(1024, 0, 2, 8'd200, 8'd255, 1'b1, 1'b0, 1'b0);

    // threshold equality counts as a match
    run_window(1024, 0, 0, 8'd255, 8'd255, 1'b1, 1'b0, 1'b0);
    run_window(512, 512, 0, 8'd0, HALF_RES, 1'b1, 1'b1, 1'b0);
    run_window(512, 512, 0, 8'd129, HALF_RES, 1'b0, 1'b1, 1'b0);

    // start coincident with the last sample discards that dump
    trigger = 8'd200;
    for (int i = 0; i < 1023; i++) drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    start = 1'b0;
    chk("start_prio_locked", locked, 0);
    run_window(1024, 0, 0, 8'd200, 8'd255, 1'b1, 1'b0, 1'b0);

    // async reset mid-window
    for (int i = 0; i < 500; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_result", result, 0);
    chk("arst_rv", result_valid, 0);
    chk("arst_match", match, 0);
    chk("arst_locked", locked, 0);
    chk("arst_slip", slip, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 1100; i++) drive(1'b1, 1'b1, 1'b1, 1'b0);
    chk("idle_result", result, 0);
    chk("idle_locked", locked, 0);
    pulse_start();
    run_window(1024, 0, 0, 8'd200, 8'd255, 1'b1, 1'b0, 1'b0);

`ifdef CORRELATOR_BIPOLAR_EN
    // inverted-code peak and balanced window
    run_window(0, 1024, 0, 8'd200, 8'd255, 1'b1, 1'b0, 1'b0);
    run_window(512, 512, 0, 8'd200, 8'd0, 1'b0, 1'b0, 1'b1);
`endif

    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/correlator_lock.md
Name: correlator_lock

Overview:
- Parametrised integrate-and-dump successor to the single-window correlator.
- Counts sig/code agreement over a programmable window of INT_LEN enabled samples and emits a scaled, saturated result per window.
- Compares each result to a trigger threshold and runs a search/track lock state machine.
- Issues slip requests to the upstream code generator so it can advance code phase until lock is achieved.

Parameters:
- INT_LEN, 1024: enabled samples per integration window (>=2).
- ACC_W, 16: accumulator width; must be >= clog2(INT_LEN+1).
- OUT_W, 8: result width.
- OUT_SHIFT, 2: right shift applied to the accumulator before output.
- LOCK_HITS, 3: consecutive matching windows needed to go SEARCH->TRACK.
- MISS_LIMIT, 2: consecutive non-matching windows needed to go TRACK->SEARCH.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  sample strobe; sig/code counted only when high.
- start  input  1  one-cycle pulse; clears window and enters SEARCH.
- sig  input  1  received hard-decision bit.
- code  input  1  local reference code bit.
- trigger  input  OUT_W  match threshold, sampled at dump.
- result  output  OUT_W  last dumped, scaled correlation value.
- result_valid  output  1  one-cycle pulse when result updates.
- match  output  1  result >= trigger for the last window; held until next dump.
- locked  output  1  high in TRACK.
- slip  output  1  one-cycle code-phase advance request.

Behaviour:
- Reset (rst_n low, async): state IDLE; acc, sample counter, hit_cnt and miss_cnt = 0; result = 0; result_valid, match, locked and slip = 0.
- FSM states are IDLE, SEARCH and TRACK. In IDLE, en is ignored.
- start in any state: clears acc, counter, hit_cnt and miss_cnt, drops locked, and enters SEARCH next cycle. start has priority over a coincident dump, which is discarded.
- Per en cycle in SEARCH/TRACK: the sample bit is (sig == code). acc += bit; counter++.
- Dump trigger: en high with counter == INT_LEN-1.
- Dump, same edge: result <= min((acc+bit) >> OUT_SHIFT, 2^OUT_W-1). acc <= 0; counter <= 0.
- There is no sample gap between windows: the next en cycle counts into the new window.
- Output timing: result_valid, match, locked and slip update on the same edge as result, i.e. 1 cycle after the last sample is presented.
- match = (new result >= trigger).
- SEARCH, dump with match: hit_cnt++. Reaching LOCK_HITS -> TRACK, locked=1, hit_cnt=0.
- SEARCH, dump without match: hit_cnt=0, slip=1 for one cycle.
- TRACK, dump with match: miss_cnt=0.
- TRACK, dump without match: miss_cnt++. Reaching MISS_LIMIT -> SEARCH, locked=0, slip=1, miss_cnt=0.
- Without a dump, result_valid and slip are 0.
- en low: no counting, no state change; outputs are held.
- Saturation: when INT_LEN >> OUT_SHIFT exceeds 2^OUT_W-1, a full-agreement window clamps to all-ones. acc itself never wraps because of the ACC_W constraint.
- Reset mid-window: everything is cleared immediately; the block stays in IDLE until start.

Optional Feature:
- Macro: CORRELATOR_BIPOLAR_EN.
- Defined: acc is signed ACC_W+1 bits and accumulates +1 on agreement and -1 on disagreement. result = min(|acc| >> OUT_SHIFT, 2^OUT_W-1). This makes an inverted-code peak also detectable.
- Undefined: unsigned agreement count as above; no sign logic.

Test Plan:
- Full agreement: start, sig==code for 1024 en cycles, trigger=200 -> one result_valid 1 cycle after the 1024th sample, result=255 (saturated from 256), match=1, slip=0, hit_cnt=1.
- Half agreement: 512 agree then 512 disagree, trigger=200 -> result=128, match=0, slip pulse coincident with result_valid, locked=0.
- Lock: three consecutive full-agreement windows -> locked rises with the third result_valid. The first sample of window 4 is counted with no gap, so result after window 4 = 255.
- Loss of lock: in TRACK, one miss then one hit -> locked stays 1. Then two consecutive misses -> locked falls and slip pulses on the second miss dump.
- en gaps: same full-agreement stimulus with en high every 3rd cycle -> result=255 after 3072 cycles; no result_valid earlier.
- Async reset: assert rst_n low at sample 500 of a window -> all outputs 0 immediately. After release, en pulses produce nothing until start; a fresh full window then gives result=255.
- Bipolar (macro defined): all-disagree window -> result=255, match=1. Equal agree/disagree -> result=0.
